sum_ram_drain: RTL and testbench

- Read-side companion of the accumulate-into-sum-RAM path.
- After a layer pass completes, it walks a selected ping-pong bank of the sum RAM through the RAM read port (O_raddr -> I_rdata0/I_rdata1).
- Each 24-bit partial sum is requantized to a narrower signed word by a rounding right shift with saturation.
- Results stream to the output buffer over a valid/ready interface with full backpressure.

---
 rtl/cnna_acc_pkg.sv | 34 +++
 rtl/sync_fifo_fwft.sv | 46 ++++
 rtl/sum_ram_drain.sv | 130 +++++++++++++
 tb/tb_sum_ram_drain.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnna_acc_pkg.sv
// Shared constants, drain FSM encoding and the round/saturate requantizer
// used by the sum-RAM read side.
package cnna_acc_pkg;

  localparam int C_DSIZE_DEF = 24;
  localparam int C_OSIZE_DEF = 16;
  localparam int C_SHW       = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } drain_state_e;

  // Round half toward +inf, then clamp; one extra bit keeps the rounding add exact.
  function automatic logic signed [C_OSIZE_DEF-1:0] sat_round(
    input logic signed [C_DSIZE_DEF-1:0] d,
    input logic        [C_SHW-1:0]       sh
  );
    logic signed [C_DSIZE_DEF:0] t, rnd, qmax, qmin;
    qmax = (C_DSIZE_DEF+1)'((1 << (C_OSIZE_DEF-1)) - 1);
    qmin = -qmax - (C_DSIZE_DEF+1)'(1);
    t    = {d[C_DSIZE_DEF-1], d};
    if (sh != '0) begin
      rnd = (C_DSIZE_DEF+1)'(1) <<< (sh - 1'b1);
      t   = (t + rnd) >>> sh;
    end
    if (t > qmax)      return qmax[C_OSIZE_DEF-1:0];
    else if (t < qmin) return qmin[C_OSIZE_DEF-1:0];
    else               return t[C_OSIZE_DEF-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head data is visible whenever vld_o is high.
module sync_fifo_fwft #(
  parameter  int W     = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          vld_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          wr, rd;

  assign rd = rd_en_i && (cnt_q != '0);
  assign wr = wr_en_i && ((cnt_q != CW'(DEPTH)) || rd);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(wr);
      rptr_q <= rptr_q + AW'(rd);
      cnt_q  <= cnt_q + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q];
  assign vld_o     = (cnt_q != '0);
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/sum_ram_drain.sv
// Walks one sum-RAM bank, requantizes each partial sum and streams it out
// through a credit-protected skid FIFO with full backpressure.
module sum_ram_drain
  import cnna_acc_pkg::*;
#(
  parameter int C_DSIZE      = C_DSIZE_DEF,
  parameter int C_OSIZE      = C_OSIZE_DEF,
  parameter int C_ASIZE      = 10,
  parameter int C_RD_LAT     = 2,
  parameter int C_FIFO_DEPTH = 8
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_start,
  input  logic               I_bank_sel,
  input  logic [C_ASIZE-1:0] I_base_addr,
  input  logic [C_ASIZE:0]   I_len,
  input  logic [C_SHW-1:0]   I_shift,
  output logic [C_ASIZE-1:0] O_raddr,
  input  logic [C_DSIZE-1:0] I_rdata0,
  input  logic [C_DSIZE-1:0] I_rdata1,
  output logic [C_OSIZE-1:0] O_dout,
  output logic               O_dv,
  input  logic               I_rdy,
  output logic               O_busy,
  output logic               O_done
);

  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;

  drain_state_e        state_q, state_d;
  logic                bank_q;
  logic [C_SHW-1:0]    shift_q;
  logic [C_ASIZE:0]    len_q, issue_cnt_q, issue_cnt_d;
  logic [C_ASIZE-1:0]  raddr_q, raddr_d;
  logic [C_RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic                q_vld_q;
  logic [C_OSIZE-1:0]  q_data_q;
  logic [CW-1:0]       fifo_cnt;
  logic [C_OSIZE-1:0]  fifo_dout;
  logic                fifo_vld, pop;
  logic                start_acc, issue, credit_ok, drained;
  logic [7:0]          used;

  assign start_acc = (state_q == S_IDLE) && I_start;
  assign pop       = fifo_vld & I_rdy;

  // Every word between issue and transfer holds a credit, so the FIFO cannot overflow.
  always_comb begin
    used = 8'(fifo_cnt) + 8'(q_vld_q);
    for (int i = 0; i < C_RD_LAT; i++) used = used + 8'(vld_pipe_q[i]);
  end
  assign credit_ok = used < 8'(C_FIFO_DEPTH);

  // The first read goes out in the start cycle itself to meet the start-to-data latency.
  assign issue = (start_acc && (I_len != '0)) ||
                 ((state_q == S_RUN) && (issue_cnt_q != len_q) && credit_ok);
  assign O_raddr     = start_acc ? I_base_addr : raddr_q;
  assign raddr_d     = O_raddr + C_ASIZE'(issue);
  assign issue_cnt_d = (start_acc ? '0 : issue_cnt_q) + (C_ASIZE+1)'(issue);

  always_comb begin
    vld_pipe_d[0] = issue;
    for (int i = 1; i < C_RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  assign drained = (vld_pipe_q == '0) && !q_vld_q &&
                   ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (I_start) state_d = (I_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issue_cnt_q == len_q) state_d = S_FLUSH;
      S_FLUSH: if (drained) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    O_busy = (state_q != S_IDLE);
    O_done = (state_q == S_DONE);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bank_q      <= 1'b0;
      shift_q     <= '0;
      len_q       <= '0;
      raddr_q     <= '0;
      issue_cnt_q <= '0;
      vld_pipe_q  <= '0;
      q_vld_q     <= 1'b0;
      q_data_q    <= '0;
    end else begin
      if (start_acc) begin
        bank_q  <= I_bank_sel;
        shift_q <= I_shift;
        len_q   <= I_len;
      end
      raddr_q     <= raddr_d;
      issue_cnt_q <= issue_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      q_vld_q     <= vld_pipe_q[C_RD_LAT-1];
      if (vld_pipe_q[C_RD_LAT-1])
        q_data_q <= sat_round(bank_q ? I_rdata1 : I_rdata0, shift_q);
    end
  end

  sync_fifo_fwft #(.W(C_OSIZE), .DEPTH(C_FIFO_DEPTH)) u_fifo (
    .clk_i     (I_clk),
    .rst_n_i   (I_rst_n),
    .wr_en_i   (q_vld_q),
    .wr_data_i (q_data_q),
    .rd_en_i   (pop),
    .rd_data_o (fifo_dout),
    .vld_o     (fifo_vld),
    .cnt_o     (fifo_cnt)
  );

  assign O_dv   = fifo_vld;
  assign O_dout = fifo_vld ? fifo_dout : '0;

endmodule

// File: tb/tb_sum_ram_drain.sv
// Bench for sum_ram_drain: RAM model with 2-cycle read latency, queue-based
// reference of requantized words, latency/credit/backpressure checks.
module tb_sum_ram_drain;

  localparam int DEPTH = 8;

  logic        clk = 0, rst_n = 0, start = 0, bank = 0, rdy = 0;
  logic [9:0]  base_a = '0;
  logic [10:0] len_a = '0;
  logic [4:0]  sh_a = '0;
  logic [9:0]  raddr;
  logic [23:0] rd0, rd1;
  logic [15:0] dout;
  logic        dv, busy, done;

  logic [23:0] mem0 [1024];
  logic [23:0] mem1 [1024];
  logic [9:0]  ra1 = '0, ra2 = '0;

  int checks = 0, failures = 0;
  int exp_q[$];
  int raddr_log[$];

  typedef struct {
    bit          bk;
    logic [23:0] d;
    int          sh;
    int          exp;
  } qvec_t;
  qvec_t tv[12];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ra1 <= raddr;
    ra2 <= ra1;
  end
  assign rd0 = mem0[ra2];
  assign rd1 = mem1[ra2];

  sum_ram_drain dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .I_bank_sel(bank),
    .I_base_addr(base_a), .I_len(len_a), .I_shift(sh_a), .O_raddr(raddr),
    .I_rdata0(rd0), .I_rdata1(rd1), .O_dout(dout), .O_dv(dv),
    .I_rdy(rdy), .O_busy(busy), .O_done(done)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference requantizer: floor((d + 2^(s-1)) / 2^s), then clamp to 16 bits.
  function automatic int quant(input logic [23:0] d24, input int sh);
    longint d, num, den, t;
    d = longint'($signed(d24));
    if (sh == 0) t = d;
    else begin
      num = d + (longint'(1) << (sh - 1));
      den = longint'(1) << sh;
      t = num / den;
      if ((num % den != 0) && (num < 0)) t = t - 1;
    end
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return int'(t);
  endfunction

  task automatic fill_model(input bit bk, input int b, input int n, input int sh);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (b + i) % 1024;
      exp_q.push_back(quant(bk ? mem1[a] : mem0[a], sh));
    end
  endtask

  function automatic logic rdy_fn(input int mode, input int cyc);
    if (mode == 1) return (cyc % 4 == 0);
    if (mode == 2) return 1'($urandom % 2);
    return 1'b1;
  endfunction

  task automatic drain(input string nm, input bit bk, input int b, input int n, input int sh,
                       input int mode, input int xstart, input int abort_n,
                       input int exp_first, input int exp_done, input bit credit_on);
    int cyc, xfers, first, done_c, credit_bad, busy_bad, hold_bad, extra, iss, e;
    bit prev_stall, timeout, aborted;
    logic [15:0] prev_dout;
    cyc = 0; xfers = 0; first = -1; done_c = -1; credit_bad = 0; busy_bad = 0;
    hold_bad = 0; extra = 0; prev_stall = 0; timeout = 0; aborted = 0; prev_dout = '0;
    raddr_log.delete();
    @(posedge clk); #1;
    start = 1; bank = bk; base_a = 10'(b); len_a = 11'(n); sh_a = 5'(sh);
    rdy = rdy_fn(mode, 0);
    while (1) begin
      @(negedge clk);
      raddr_log.push_back(int'(raddr));
      if (credit_on) begin
        iss = (int'(raddr) - b) & 1023;
        if ((iss - xfers > DEPTH) || (iss > n)) credit_bad++;
      end
      if (cyc == 0 ? busy : (!busy && !done)) busy_bad++;
      if (prev_stall && (dout != prev_dout)) hold_bad++;
      prev_stall = dv && !rdy;
      prev_dout  = dout;
      if (dv && rdy) begin
        if (first < 0) first = cyc;
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          chk($sformatf("%s_word%0d", nm, xfers), int'($signed(dout)), e);
        end
        xfers++;
      end
      if (done) begin done_c = cyc; break; end
      if ((abort_n >= 0) && (xfers == abort_n)) begin aborted = 1; break; end
      if (cyc > 8 * n + 50) begin timeout = 1; break; end
      @(posedge clk); #1;
      cyc++;
      start = (cyc == xstart);
      if (start) begin bank = ~bk; base_a = 10'(b + 100); len_a = 11'(5); end
      rdy = rdy_fn(mode, cyc);
    end
    if (aborted) begin exp_q.delete(); return; end
    chk({nm, "_timeout"}, timeout, 0);
    chk({nm, "_count"}, xfers, n);
    chk({nm, "_extra"}, extra, 0);
    chk({nm, "_left"}, exp_q.size(), 0);
    if (exp_first >= 0) chk({nm, "_first_dv"}, first, exp_first);
    if (exp_done >= 0) chk({nm, "_done_cyc"}, done_c, exp_done);
    if (credit_on) chk({nm, "_credit"}, credit_bad, 0);
    chk({nm, "_busy"}, busy_bad, 0);
    chk({nm, "_hold"}, hold_bad, 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n, b, sh;
    bit bk;
    tv[0]  = '{1'b1, 24'h000018, 4, 2};
    tv[1]  = '{1'b1, 24'hFFFFE8, 4, -1};
    tv[2]  = '{1'b0, 24'h7FFFFF, 0, 32767};
    tv[3]  = '{1'b0, 24'h800000, 0, -32768};
    tv[4]  = '{1'b0, 24'h7FFFFF, 23, 1};
    tv[5]  = '{1'b1, 24'h800000, 23, -1};
    tv[6]  = '{1'b0, 24'h012345, 8, 291};
    tv[7]  = '{1'b1, 24'h7FFFFF, 1, 32767};
    tv[8]  = '{1'b0, 24'hFFFFD8, 4, -2};
    tv[9]  = '{1'b1, 24'hFFFFF8, 4, 0};
    tv[10] = '{1'b0, 24'h008000, 0, 32767};
    tv[11] = '{1'b1, 24'hFF7FFF, 0, -32768};

    for (int a = 0; a < 1024; a++) begin
      mem0[a] = 24'(a * 3);
      mem1[a] = 24'($urandom);
    end

    repeat (3) @(negedge clk);
    chk("reset_outputs", {raddr, dout, dv, busy, done}, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_reset_outputs", {dout, dv, busy, done}, 0);

    // basic drain with exact latency
    exp_q = '{0, 3, 6, 9};
    drain("basic", 0, 0, 4, 0, 0, -1, -1, 4, 8, 1);

    // quantizer vectors, one word each, opposite bank holds decoy data
    for (int i = 0; i < 12; i++) begin
      if (tv[i].bk) begin mem1[300] = tv[i].d; mem0[300] = ~tv[i].d; end
      else          begin mem0[300] = tv[i].d; mem1[300] = ~tv[i].d; end
      exp_q.push_back(tv[i].exp);
      drain($sformatf("qv%0d", i), tv[i].bk, 300, 1, tv[i].sh, 0, -1, -1, 4, 5, 1);
    end

    for (int a = 0; a < 1024; a++) begin
      mem0[a] = ($urandom % 2) ? 24'($urandom) : 24'($signed(20'($urandom)));
      mem1[a] = 24'($urandom);
    end

    // backpressure 1 on / 3 off exhausts credits
    fill_model(1, 500, 16, 3);
    drain("bp", 1, 500, 16, 3, 1, -1, -1, -1, -1, 1);

    // address wrap
    fill_model(0, 1022, 4, 2);
    drain("wrap", 0, 1022, 4, 2, 0, -1, -1, 4, 8, 1);
    chk("wrap_ra0", raddr_log[0], 1022);
    chk("wrap_ra1", raddr_log[1], 1023);
    chk("wrap_ra2", raddr_log[2], 0);
    chk("wrap_ra3", raddr_log[3], 1);

    // zero length
    drain("len0", 0, 10, 0, 0, 0, -1, -1, -1, 1, 1);

    // second start while busy is ignored
    fill_model(0, 200, 6, 5);
    drain("xstart_busy", 0, 200, 6, 5, 0, 3, -1, 4, 10, 1);

    // start coincident with O_done is ignored
    fill_model(1, 40, 4, 0);
    drain("xstart_done", 1, 40, 4, 0, 0, 8, -1, 4, 8, 1);
    @(posedge clk); #1 start = 0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || dv || done) bad++;
    end
    chk("xstart_done_idle", bad, 0);

    // reset mid-drain
    fill_model(0, 50, 8, 1);
    drain("abort", 0, 50, 8, 1, 0, -1, 3, -1, -1, 1);
    @(posedge clk); #1 rst_n = 0;
    #1 chk("abort_rst_outputs", {raddr, dout, dv, busy, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (dv || done || busy) bad++;
    end
    chk("abort_quiet", bad, 0);
    fill_model(0, 50, 8, 1);
    drain("after_abort", 0, 50, 8, 1, 0, -1, -1, 4, 12, 1);

    // randomized drains under random backpressure
    for (int i = 0; i < 15; i++) begin
      b  = int'($urandom % 1024);
      n  = int'($urandom_range(1, 40));
      bk = 1'($urandom % 2);
      sh = int'($urandom % 24);
      fill_model(bk, b, n, sh);
      drain($sformatf("rnd%0d", i), bk, b, n, sh, 2, -1, -1, -1, -1, 1);
    end

    // full bank
    fill_model(1, 7, 1024, 6);
    drain("full", 1, 7, 1024, 6, 0, -1, -1, 4, 1028, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
